// File: rtl/icache_dm_pkg.sv
// icache_dm_pkg: shared types and constants for the direct-mapped instruction cache.
//   word_tp / line_tp / addr_tp : 32-bit word, 128-bit line, 32-bit default address
//   TRUE / FALSE / ZERO_ADDR    : named constants
//   state_t                     : controller states IDLE / MISS / DROP
//   sel_word()                  : picks 32-bit word k (0..3) out of a line
package icache_dm_pkg;

   localparam int WORD_W = 32;
   localparam int LINE_W = 128;
   localparam int ADDR_W_DEF = 32;

   typedef logic [WORD_W-1:0]     word_tp;
   typedef logic [LINE_W-1:0]     line_tp;
   typedef logic [ADDR_W_DEF-1:0] addr_tp;

   localparam logic   TRUE      = 1'b1;
   localparam logic   FALSE     = 1'b0;
   localparam addr_tp ZERO_ADDR = '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MISS = 2'd1,
      DROP = 2'd2
   } state_t;

   // Word k sits at line[32k+31:32k]; byte 0 of the line is line[7:0].
   function automatic word_tp sel_word(input line_tp line, input logic [1:0] sel);
      word_tp w;
      case (sel)
         2'd0:    w = line[31:0];
         2'd1:    w = line[63:32];
         2'd2:    w = line[95:64];
         default: w = line[127:96];
      endcase
      return w;
   endfunction

endpackage

// File: rtl/icache_dm_if.sv
// icache_dm_if: fetch-side and memory-controller-side signals of the cache.
//   slave  : the cache's view (takes fetch requests, issues line fetches)
//   master : the environment's view (fetch unit + memory controller)
//
// Handshakes:
//   Fetch: the fetch unit raises if_valid with a stable if_addr and holds
//   both until the cache pulses if_done for one cycle (if_inst valid in that
//   cycle) or until it pulses flush. flush discards any pending response.
//   Line fetch: the cache raises fc_valid with a stable line-aligned fc_addr
//   and holds both until the memory controller pulses fc_done for one cycle
//   with fc_line valid. fc_valid falls on the edge that samples fc_done, so
//   the same fetch is never launched twice. A fetch is never withdrawn.
interface icache_dm_if #(
   parameter int ADDR_W = 32
);
   import icache_dm_pkg::*;

   logic              flush;
   logic              if_valid;
   logic [ADDR_W-1:0] if_addr;
   logic              if_done;
   word_tp            if_inst;
   logic              fc_valid;
   logic [ADDR_W-1:0] fc_addr;
   logic              fc_done;
   line_tp            fc_line;

   modport slave (
      input  flush, if_valid, if_addr, fc_done, fc_line,
      output if_done, if_inst, fc_valid, fc_addr
   );

   modport master (
      output flush, if_valid, if_addr, fc_done, fc_line,
      input  if_done, if_inst, fc_valid, fc_addr
   );

endinterface

// File: rtl/icache_array.sv
// icache_array: valid/tag/data storage for the direct-mapped cache.
//   clk, rst_n          : clock, async active-low reset (clears valid bits only)
//   rd_idx              : combinational lookup index
//   rd_valid/tag/data   : stored contents of line rd_idx
//   wr_en/idx/tag/data  : single write port, installs a line and sets its valid bit
module icache_array
   import icache_dm_pkg::*;
#(
   parameter int IDX_W = 4,
   parameter int TAG_W = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_valid,
   output logic [TAG_W-1:0] rd_tag,
   output line_tp           rd_data,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0] wr_tag,
   input  line_tp           wr_data
);

   localparam int LINES = 1 << IDX_W;

   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_mem  [LINES];
   line_tp           data_mem [LINES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_idx] <= TRUE;
      end
   end

   // Tag and data need no reset: they are only read behind a valid bit.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_idx]  <= wr_tag;
         data_mem[wr_idx] <= wr_data;
      end
   end

   assign rd_valid = valid_q[rd_idx];
   assign rd_tag   = tag_mem[rd_idx];
   assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache, 2^IDX_W lines of 16 bytes.
//   clk, rst_n : clock, async active-low reset
//   rdy        : global ready; low freezes all state (if_done forced low)
//   bus        : fetch request/response and line-fetch signals (slave view)
//   state      : current controller state, for observation
// Hits answer one cycle after the request. A miss fetches the whole line,
// installs it and answers on the fc_done edge. A flush during a miss moves
// to DROP: the line is still installed when it arrives but nothing is
// returned to fetch.
module icache_dm
   import icache_dm_pkg::*;
#(
   parameter int IDX_W  = 4,
   parameter int ADDR_W = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rdy,
   icache_dm_if.slave  bus,
   output state_t      state
);

   localparam int TAG_W = ADDR_W - 4 - IDX_W;

   state_t            state_q, state_n;
   logic              if_done_q, if_done_n;
   word_tp            if_inst_q, if_inst_n;
   logic              fc_valid_q, fc_valid_n;
   logic [ADDR_W-1:0] fc_addr_q, fc_addr_n;
   logic [ADDR_W-1:0] miss_addr_q, miss_addr_n;

   logic              rd_valid;
   logic [TAG_W-1:0]  rd_tag;
   line_tp            rd_data;
   logic              hit;
   logic              wr_en;

   // Word-aligned addresses: the byte-offset bits carry no information.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.if_addr[1:0], miss_addr_q[1:0]};

   icache_array #(
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
   ) u_array (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_idx   (bus.if_addr[4+IDX_W-1:4]),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .wr_en    (wr_en),
      .wr_idx   (miss_addr_q[4+IDX_W-1:4]),
      .wr_tag   (miss_addr_q[ADDR_W-1:4+IDX_W]),
      .wr_data  (bus.fc_line)
   );

   assign hit = rd_valid && (rd_tag == bus.if_addr[ADDR_W-1:4+IDX_W]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         if_done_q   <= FALSE;
         if_inst_q   <= '0;
         fc_valid_q  <= FALSE;
         fc_addr_q   <= '0;
         miss_addr_q <= '0;
      end else begin
         state_q     <= state_n;
         if_done_q   <= if_done_n;
         if_inst_q   <= if_inst_n;
         fc_valid_q  <= fc_valid_n;
         fc_addr_q   <= fc_addr_n;
         miss_addr_q <= miss_addr_n;
      end
   end

   always_comb begin
      state_n     = state_q;
      if_done_n   = FALSE;
      if_inst_n   = if_inst_q;
      fc_valid_n  = fc_valid_q;
      fc_addr_n   = fc_addr_q;
      miss_addr_n = miss_addr_q;
      wr_en       = FALSE;
      if (rdy) begin
         case (state_q)
            IDLE: begin
               if (bus.if_valid && !bus.flush) begin
                  if (hit) begin
                     if_done_n = TRUE;
                     if_inst_n = sel_word(rd_data, bus.if_addr[3:2]);
                  end else begin
                     fc_valid_n  = TRUE;
                     fc_addr_n   = {bus.if_addr[ADDR_W-1:4], 4'b0000};
                     miss_addr_n = bus.if_addr;
                     state_n     = MISS;
                  end
               end
            end
            MISS: begin
               if (bus.fc_done) begin
                  wr_en      = TRUE;
                  fc_valid_n = FALSE;
                  state_n    = IDLE;
                  if (!bus.flush) begin
                     if_done_n = TRUE;
                     if_inst_n = sel_word(bus.fc_line, miss_addr_q[3:2]);
                  end
               end else if (bus.flush) begin
                  // The controller cannot abort, so keep fc_valid up and
                  // absorb the line when it comes back.
                  state_n = DROP;
               end
            end
            DROP: begin
               if (bus.fc_done) begin
                  wr_en      = TRUE;
                  fc_valid_n = FALSE;
                  state_n    = IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   assign bus.if_done  = if_done_q;
   assign bus.if_inst  = if_inst_q;
   assign bus.fc_valid = fc_valid_q;
   assign bus.fc_addr  = fc_addr_q;
   assign state        = state_q;

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped instruction cache between the instruction-fetch unit and the memory controller's fetch port.
- Serves 32-bit instruction words to fetch.
- On a miss, requests one 16-byte line from the memory controller, installs it, then returns the requested word.
- Supports a fetch flush (branch rollback) that discards an outstanding response without corrupting the cache.

Parameters:
- IDX_W, 4: index bits; the cache holds 2^IDX_W lines of 16 bytes.
- ADDR_W, 32: byte-address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- rdy  in  1  global ready. When low, all state freezes.
- flush  in  1  rollback. Drops the pending fetch response.
- if_valid  in  1  fetch request. Held high with a stable if_addr until if_done or flush.
- if_addr  in  ADDR_W  instruction address, word-aligned.
- if_done  out  1  one-cycle pulse: if_inst is valid.
- if_inst  out  32  returned instruction word.
- fc_valid  out  1  line-fetch request to the memory controller.
- fc_addr  out  ADDR_W  line-aligned fetch address; bits [3:0] = 0.
- fc_done  in  1  one-cycle pulse: fc_line is valid.
- fc_line  in  128  fetched line; byte 0 in bits [7:0].

Behaviour:
- Address split:
  - tag = addr[ADDR_W-1:4+IDX_W]
  - idx = addr[4+IDX_W-1:4]
  - word select = addr[3:2]; word k = line[32k+31:32k]
- Storage per line: valid bit, tag, 128-bit data.
- Reset (rst_n low, asynchronous), takes effect immediately:
  - all valid bits = 0; state = IDLE
  - if_done = 0, if_inst = 0, fc_valid = 0, fc_addr = 0
  - data and tag arrays need no reset.
- rdy = 0: no state or array change. if_done is driven 0 at that edge. fc_valid/fc_addr hold.
- States: IDLE, MISS, DROP.
- IDLE, if_valid = 1, flush = 0, hit (valid[idx] and tag match):
  - next edge: if_done = 1, if_inst = selected word.
  - Latency 1 cycle. Stay in IDLE.
  - Back-to-back hits are accepted one per cycle. The requester drops or changes if_valid/if_addr the cycle after if_done.
- IDLE, if_valid = 1, flush = 0, miss:
  - next edge: fc_valid = 1, fc_addr = {if_addr[ADDR_W-1:4], 4'b0}; go to MISS.
  - Miss address latched internally.
- MISS, fc_done = 1, flush = 0, on that edge:
  - write the line: valid = 1, tag, data = fc_line.
  - fc_valid = 0; if_done = 1; if_inst = word from fc_line selected by the latched addr[3:2]; go to IDLE.
  - Miss latency = memory-controller latency + 1.
- MISS, flush = 1, fc_done = 0: go to DROP. fc_valid stays 1, because the memory controller cannot abort a fetch.
- MISS or DROP, fc_done = 1 together with flush = 1: install the line, no if_done, go to IDLE.
- DROP, fc_done = 1: install the line, fc_valid = 0, no if_done, go to IDLE.
- DROP ignores if_valid.
- IDLE, flush = 1: no response. if_valid is ignored that cycle.
- fc_valid drops on the same edge that samples fc_done. This guarantees the memory controller never relaunches a duplicate fetch.
- fc_done outside MISS/DROP: ignored.
- Replacement: direct-mapped overwrite, no write-back (read-only cache).
- Lines are never invalidated except by reset.

Decomposition:
- Shared package/header:
  - ADDR_TP, WORD_TP and a LINE_TP (127:0) width macro
  - TRUE/FALSE and ZERO_ADDR constants
  - state encodings IDLE/MISS/DROP
- One natural sub-module: icache_array (valid/tag/data storage, combinational read, single write port, async clear of valid bits).
- FSM and port logic stay in icache_dm.

Test Plan:
- Cold miss: after reset, if_valid = 1, if_addr = 0x00000008 -> next cycle fc_valid = 1, fc_addr = 0x00000000. Return fc_line = 0x33333333_22222222_11111111_00000000 -> one cycle later if_done = 1, if_inst = 0x22222222.
- Hit: then request 0x0000000C -> if_done = 1 after 1 cycle, if_inst = 0x33333333, fc_valid stays 0.
- Conflict eviction (IDX_W = 4): fetch 0x00000100 (same idx 0, new tag) -> miss, line replaced. Re-fetch 0x00000000 -> miss again.
- Flush mid-miss: miss on 0x00000040, pulse flush before fc_done -> fc_valid stays 1 until fc_done, no if_done. A later request to 0x00000044 hits in 1 cycle.
- rdy stall: hold rdy = 0 for 3 cycles during MISS with fc_done = 0 -> fc_valid/fc_addr unchanged, if_done = 0. Resumes normally after rdy = 1.
- Async reset mid-miss: drop rst_n between clock edges while in MISS -> fc_valid = 0 immediately. After release, a previously cached address misses.
